// File: rtl/multi_slot_bridge.sv
// multi_slot_bridge: registered CPU bridge to data memory and N_SLOTS memory-mapped peripheral slots with wait states, fault reporting and IRQ aggregation
module multi_slot_bridge #(
    parameter int          N_SLOTS     = 2,
    parameter logic [31:0] DM_LIMIT    = 32'h0002_ffff,
    parameter logic [31:0] SLOT_BASE   = 32'h0000_7f00,
    parameter logic [31:0] SLOT_STRIDE = 32'h10,
    parameter int          SLOT_SIZE   = 12,
    parameter int          TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_req,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_byteen,
    output logic [31:0]          m_rdata,
    output logic                 m_ack,
    output logic                 m_busy,
    output logic                 m_fault,
    output logic [31:0]          fault_addr,
    output logic [31:0]          dm_addr,
    output logic [31:0]          dm_wdata,
    output logic [3:0]           dm_byteen,
    input  logic [31:0]          dm_rdata,
    output logic [N_SLOTS-1:0]   dev_sel,
    output logic [N_SLOTS-1:0]   dev_we,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    input  logic [32*N_SLOTS-1:0] dev_rdata,
    input  logic [N_SLOTS-1:0]   dev_ready,
    input  logic [N_SLOTS-1:0]   irq_in,
    output logic [5:0]           hw_int
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [32:0] REG_END = {1'b0, SLOT_BASE} + 33'(N_SLOTS) * {1'b0, SLOT_STRIDE};
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, next_state;
    logic [31:0] a_addr, a_wdata, slot_rdata;
    logic [3:0] a_be;
    logic [CW-1:0] cnt;
    logic fault, in_region, is_dm, slot_hit, ready, expire, acc;
    logic [N_SLOTS-1:0] hit;
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_hit
        localparam logic [32:0] LO = {1'b0, SLOT_BASE} + 33'(i) * {1'b0, SLOT_STRIDE};
        localparam logic [32:0] HI = LO + 33'(SLOT_SIZE - 1);
        assign hit[i] = {1'b0, a_addr} >= LO && {1'b0, a_addr} <= HI;
    end
    always_comb begin
        in_region = a_addr >= SLOT_BASE && {1'b0, a_addr} < REG_END;
        is_dm = !in_region && a_addr <= DM_LIMIT;
        slot_hit = |hit;
        ready = |(hit & dev_ready);
        expire = cnt == CW'(TIMEOUT - 1);
        acc = state == ACCESS;
        slot_rdata = '0;
        for (int k = 0; k < N_SLOTS; k++)
            slot_rdata = slot_rdata | (hit[k] ? dev_rdata[32*k +: 32] : 32'h0);
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : next_state;
    always_comb begin
        next_state = state == IDLE   ? (m_req ? ACCESS : IDLE) :
                     state == ACCESS ? ((!slot_hit || ready || expire) ? RESP : ACCESS) :
                                       IDLE;
    end
    always_comb begin
        m_ack     = state == RESP;
        m_fault   = state == RESP && fault;
        m_busy    = state != IDLE;
        dm_addr   = acc && is_dm ? a_addr : '0;
        dm_wdata  = acc && is_dm ? a_wdata : '0;
        dm_byteen = acc && is_dm ? a_be : '0;
        dev_sel   = acc ? hit : '0;
        dev_we    = acc && |a_be ? hit : '0;
        dev_addr  = acc && slot_hit ? a_addr : '0;
        dev_wdata = acc && slot_hit ? a_wdata : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            a_addr     <= '0;
            a_wdata    <= '0;
            a_be       <= '0;
            cnt        <= '0;
            fault      <= 1'b0;
            m_rdata    <= '0;
            fault_addr <= '0;
            hw_int     <= '0;
        end else begin
            hw_int <= 6'(irq_in);
            if (state == IDLE && m_req) begin
                a_addr  <= m_addr;
                a_wdata <= m_wdata;
                a_be    <= m_byteen;
            end
            if (acc) begin
                if (is_dm)
                    m_rdata <= dm_rdata;
                else if (ready)
                    m_rdata <= slot_rdata;
                else if (!slot_hit || expire) begin
                    fault      <= 1'b1;
                    m_rdata    <= '0;
                    fault_addr <= a_addr;
                end else
                    cnt <= cnt + 1'b1;
            end
            if (state == RESP) begin
                cnt   <= '0;
                fault <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multi_slot_bridge.sv
// tb_multi_slot_bridge: table-driven scoreboard bench for multi_slot_bridge
module tb_multi_slot_bridge;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          w0;
        int          w1;
        logic [1:0]  noise;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          sc;
        logic [1:0]  sel;
        logic [1:0]  we;
        int          bc;
        logic [31:0] fa;
    } vec_t;
    typedef struct {
        vec_t v;
        int   t0;
        int   idx;
    } exp_t;
    logic clk = 0, reset = 1, m_req = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata, fault_addr, dm_addr, dm_wdata, dm_rdata, dev_addr, dev_wdata;
    logic [3:0] m_byteen = 0, dm_byteen;
    logic m_ack, m_busy, m_fault;
    logic [1:0] dev_sel, dev_we, dev_ready, irq_in = 0, noise = 0;
    logic [63:0] dev_rdata = {32'h0000_0042, 32'h5a5a_0000};
    logic [5:0] hw_int;
    logic [31:0] mem [256] = '{default: 32'h0};
    int sel_cnt [2] = '{0, 0};
    int wait_n [2] = '{0, 0};
    int cyc = 0, n_tests = 0, n_fail = 0;
    exp_t sb [$];
    vec_t vt [14];

    multi_slot_bridge dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .m_rdata(m_rdata), .m_ack(m_ack), .m_busy(m_busy),
        .m_fault(m_fault), .fault_addr(fault_addr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_byteen(dm_byteen), .dm_rdata(dm_rdata), .dev_sel(dev_sel), .dev_we(dev_we),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
        .dev_ready(dev_ready), .irq_in(irq_in), .hw_int(hw_int)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: byte-enabled word writes, combinational reads
    always @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (dm_byteen[b]) mem[dm_addr[9:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    always_comb dm_rdata = mem[dm_addr[9:2]];

    // Slot model: ready once selected for wait_n cycles; noise drives unselected slots
    always @(posedge clk)
        for (int i = 0; i < 2; i++) sel_cnt[i] <= dev_sel[i] ? sel_cnt[i] + 1 : 0;
    always_comb begin
        dev_ready = '0;
        for (int i = 0; i < 2; i++)
            dev_ready[i] = dev_sel[i] ? (sel_cnt[i] >= wait_n[i]) : noise[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        int be_c, sel_c;
        logic [1:0] sel_o, we_o;
        exp_t e;
        be_c = 0; sel_c = 0; sel_o = 0; we_o = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                be_c = 0; sel_c = 0; sel_o = 0; we_o = 0;
            end else begin
                if (dm_byteen != 0) be_c++;
                if (dev_sel != 0) sel_c++;
                sel_o |= dev_sel;
                we_o |= dev_we;
                if (m_ack) begin
                    if (sb.size() == 0) chk("unexpected_ack", 32'(m_ack), 32'h0);
                    else begin
                        e = sb.pop_front();
                        chk($sformatf("v%0d_rdata", e.idx), m_rdata, e.v.rdata);
                        chk($sformatf("v%0d_fault", e.idx), 32'(m_fault), 32'(e.v.fault));
                        chk($sformatf("v%0d_latency", e.idx), 32'(cyc - e.t0), 32'(e.v.lat));
                        chk($sformatf("v%0d_sel_cycles", e.idx), 32'(sel_c), 32'(e.v.sc));
                        chk($sformatf("v%0d_sel", e.idx), 32'(sel_o), 32'(e.v.sel));
                        chk($sformatf("v%0d_we", e.idx), 32'(we_o), 32'(e.v.we));
                        chk($sformatf("v%0d_dm_be_cycles", e.idx), 32'(be_c), 32'(e.v.bc));
                        chk($sformatf("v%0d_fault_addr", e.idx), fault_addr, e.v.fa);
                    end
                    be_c = 0; sel_c = 0; sel_o = 0; we_o = 0;
                end
            end
        end
    end

    task automatic run(input vec_t v, input int idx);
        @(posedge clk); #1;
        wait_n[0] = v.w0;
        wait_n[1] = v.w1;
        noise = v.noise;
        m_req = 1; m_addr = v.addr; m_wdata = v.wdata; m_byteen = v.be;
        sb.push_back('{v, cyc, idx});
        for (int n = 0; n < 40 && !m_ack; n++) @(negedge clk);
        if (!m_ack) chk($sformatf("v%0d_ack_timeout", idx), 32'(m_ack), 32'h1);
        @(posedge clk); #1;
        m_req = 0; m_addr = 0; m_wdata = 0; m_byteen = 0; noise = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //          addr         wdata          be    w0   w1 noise rdata          f  lat sc sel    we     bc fa
        vt[0]  = '{32'h1000,    32'hdeadbeef, 4'hf, 0,   0, 2'b00, 32'h0,        0, 2,  0, 2'b00, 2'b00, 1, 32'h0};
        vt[1]  = '{32'h1000,    32'h0,        4'h0, 0,   0, 2'b00, 32'hdeadbeef, 0, 2,  0, 2'b00, 2'b00, 0, 32'h0};
        vt[2]  = '{32'h7f14,    32'h0,        4'h0, 0,   3, 2'b00, 32'h42,       0, 5,  4, 2'b10, 2'b00, 0, 32'h0};
        vt[3]  = '{32'h7f0b,    32'h12345678, 4'h3, 0,   0, 2'b00, 32'h5a5a0000, 0, 2,  1, 2'b01, 2'b01, 0, 32'h0};
        vt[4]  = '{32'h7f08,    32'h0,        4'h0, 255, 0, 2'b00, 32'h0,        1, 17, 16, 2'b01, 2'b00, 0, 32'h7f08};
        vt[5]  = '{32'h7f0c,    32'h0,        4'h0, 0,   0, 2'b00, 32'h0,        1, 2,  0, 2'b00, 2'b00, 0, 32'h7f0c};
        vt[6]  = '{32'h30000,   32'hffffffff, 4'hf, 0,   0, 2'b00, 32'h0,        1, 2,  0, 2'b00, 2'b00, 0, 32'h30000};
        vt[7]  = '{32'h1000,    32'h0,        4'h0, 0,   0, 2'b00, 32'hdeadbeef, 0, 2,  0, 2'b00, 2'b00, 0, 32'h30000};
        vt[8]  = '{32'h2ffff,   32'h000000a5, 4'h1, 0,   0, 2'b00, 32'h0,        0, 2,  0, 2'b00, 2'b00, 1, 32'h30000};
        vt[9]  = '{32'h2ffff,   32'h0,        4'h0, 0,   0, 2'b00, 32'h000000a5, 0, 2,  0, 2'b00, 2'b00, 0, 32'h30000};
        vt[10] = '{32'h7f00,    32'h0,        4'h0, 15,  0, 2'b00, 32'h5a5a0000, 0, 17, 16, 2'b01, 2'b00, 0, 32'h30000};
        vt[11] = '{32'h7f10,    32'h0,        4'h0, 0,   2, 2'b01, 32'h42,       0, 4,  3, 2'b10, 2'b00, 0, 32'h30000};
        vt[12] = '{32'h7f1c,    32'h0,        4'h0, 0,   0, 2'b00, 32'h0,        1, 2,  0, 2'b00, 2'b00, 0, 32'h7f1c};
        vt[13] = '{32'h7f0c,    32'hcafef00d, 4'hf, 0,   0, 2'b00, 32'h0,        1, 2,  0, 2'b00, 2'b00, 0, 32'h7f0c};

        irq_in = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(m_ack), 32'h0);
        chk("rst_busy", 32'(m_busy), 32'h0);
        chk("rst_fault", 32'(m_fault), 32'h0);
        chk("rst_rdata", m_rdata, 32'h0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_hw_int", 32'(hw_int), 32'h0);
        chk("rst_dev_sel", 32'(dev_sel), 32'h0);
        chk("rst_dm_byteen", 32'(dm_byteen), 32'h0);
        @(posedge clk); #1;
        reset = 0;
        irq_in = 0;

        for (int i = 0; i < 14; i++) run(vt[i], i);

        @(posedge clk); #1;
        wait_n[0] = 255;
        m_req = 1; m_addr = 32'h7f00; m_byteen = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(m_busy), 32'h1);
        reset = 1; m_req = 0; m_addr = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("abort_dev_sel", 32'(dev_sel), 32'h0);
        chk("abort_busy", 32'(m_busy), 32'h0);
        chk("abort_ack", 32'(m_ack), 32'h0);
        chk("abort_fault_addr", fault_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(m_ack), 32'h0);
        end
        v = vt[1];
        v.fa = 32'h0;
        run(v, 20);

        v = '{32'h7f14, 32'h0, 4'h0, 0, 6, 2'b00, 32'h42, 0, 8, 7, 2'b10, 2'b00, 0, 32'h0};
        fork
            run(v, 21);
            begin
                repeat (2) @(posedge clk);
                #1 irq_in = 2'b10;
                @(negedge clk);
                chk("irq_busy", 32'(m_busy), 32'h1);
                chk("irq_not_yet", 32'(hw_int), 32'h0);
                @(negedge clk);
                chk("irq_set", 32'(hw_int), 32'h2);
                @(posedge clk);
                #1 irq_in = 2'b00;
                @(negedge clk);
                chk("irq_hold", 32'(hw_int), 32'h2);
                @(negedge clk);
                chk("irq_clear", 32'(hw_int), 32'h0);
            end
        join

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
